// File: rtl/cache_control_if.sv
// Bus between the L1 cache controller and its datapath / physical-memory port.
// The controller drives the master side; the datapath and memory model form the slave side.
interface cache_control_if;
    logic mem_read;
    logic mem_write;
    logic miss;
    logic dirty;
    logic evict;
    logic read;
    logic commit;
    logic pmem_read;
    logic pmem_write;
    logic pmem_resp;

    modport master (
        input  mem_read,
        input  mem_write,
        input  miss,
        input  dirty,
        input  pmem_resp,
        output evict,
        output read,
        output commit,
        output pmem_read,
        output pmem_write
    );

    modport slave (
        output mem_read,
        output mem_write,
        output miss,
        output dirty,
        output pmem_resp,
        input  evict,
        input  read,
        input  commit,
        input  pmem_read,
        input  pmem_write
    );
endinterface

// File: rtl/cache_control.sv
// Miss sequencer for a 2-way set-associative L1: writes back dirty victims, fills lines,
// and keeps saturating hit / miss / writeback counters.
module cache_control #(
    parameter int unsigned CNT_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    cache_control_if.master    bus,
    input  logic               clr_stats_i,
    output logic               busy_o,
    output logic [CNT_W-1:0]   hit_count_o,
    output logic [CNT_W-1:0]   miss_count_o,
    output logic [CNT_W-1:0]   wb_count_o
);

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] WRITEBACK = 2'd1;
    localparam logic [1:0] FILL      = 2'd2;

    logic [1:0]       state_q, state_d;
    logic             replay_q, replay_d;
    logic [CNT_W-1:0] hit_q, hit_d;
    logic [CNT_W-1:0] miss_q, miss_d;
    logic [CNT_W-1:0] wb_q, wb_d;

    logic in_idle;
    logic access;
    logic hit_inc;
    logic miss_inc;
    logic wb_inc;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign in_idle  = (state_q == IDLE);
    assign access   = bus.mem_read | bus.mem_write;
    // The first IDLE cycle after a fill is the re-presented access, not a hit.
    assign hit_inc  = in_idle && access && !bus.miss && !replay_q;
    assign miss_inc = in_idle && bus.miss;
    assign wb_inc   = (state_q == WRITEBACK) && bus.pmem_resp;

    // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
    always_comb begin
        state_d  = state_q;
        replay_d = replay_q;
        unique case (state_q)
            IDLE: begin
                replay_d = 1'b0;
                if (bus.miss) begin
                    state_d = bus.dirty ? WRITEBACK : FILL;
                end
            end
            WRITEBACK: begin
                if (bus.pmem_resp) begin
                    state_d = FILL;
                end
            end
            FILL: begin
                if (bus.pmem_resp) begin
                    state_d  = IDLE;
                    replay_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        hit_d  = hit_q;
        miss_d = miss_q;
        wb_d   = wb_q;
        if (clr_stats_i) begin
            hit_d  = '0;
            miss_d = '0;
            wb_d   = '0;
        end else begin
            if (hit_inc)  hit_d  = sat_inc(hit_q);
            if (miss_inc) miss_d = sat_inc(miss_q);
            if (wb_inc)   wb_d   = sat_inc(wb_q);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            replay_q <= 1'b0;
            hit_q    <= '0;
            miss_q   <= '0;
            wb_q     <= '0;
        end else begin
            state_q  <= state_d;
            replay_q <= replay_d;
            hit_q    <= hit_d;
            miss_q   <= miss_d;
            wb_q     <= wb_d;
        end
    end

    // Outputs decode straight from state, so an async reset drops them immediately.
    assign bus.evict      = (state_q == WRITEBACK);
    assign bus.pmem_write = (state_q == WRITEBACK);
    assign bus.read       = (state_q == FILL);
    assign bus.pmem_read  = (state_q == FILL);
    assign bus.commit     = (state_q == FILL) && bus.pmem_resp;
    assign busy_o         = !in_idle;

    assign hit_count_o  = hit_q;
    assign miss_count_o = miss_q;
    assign wb_count_o   = wb_q;

endmodule
